// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO register map, FSM states and
// read-source encodings.
package mem_io_responder_pkg;

   localparam logic [17:0] IoDataAddr = 18'h30000;
   localparam logic [17:0] IoCntAddr  = 18'h30004;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      SrcRam,
      SrcRx,
      SrcCnt,
      SrcZero
   } rd_src_e;

   function automatic logic [7:0] snap_byte(input logic [31:0] v, input logic [1:0] idx);
      case (idx)
         2'd0:    return v[7:0];
         2'd1:    return v[15:8];
         2'd2:    return v[23:16];
         default: return v[31:24];
      endcase
   endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// Byte FIFO for the UART transmit path; pushes to a full FIFO are dropped.
module mem_io_responder_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [7:0]  push_data,
   input  logic        pop,
   output logic [7:0]  head,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full    = (cnt_q == FullCount);
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mem_io_responder.sv
// CPU memory responder: routes byte accesses to RAM or to a small IO map holding a
// UART RX/TX data port, a cycle counter snapshot and a program-stop register.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int unsigned TX_DEPTH = 8,
   parameter int unsigned RAM_AW   = 17
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [31:0]       mem_a,
   input  logic [7:0]        mem_dout,
   input  logic              mem_wr,
   output logic [7:0]        mem_din,
   output logic              io_buffer_full,
   output logic [RAM_AW-1:0] ram_a,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_pop,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              program_finish
);

   localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
   localparam logic [CW-1:0] NearFull = CW'(TX_DEPTH - 2);

   logic          is_io, io_rd, io_wr, hit_data, hit_cnt, hit_stop;
   logic          push, pop, go_drain, overflow_q;
   logic [7:0]    push_data;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   cnt_q, snap_q;
   logic [7:0]    io_byte_q;
   rd_src_e       src_q;
   state_e        state_q;
   logic          unused_addr;

   assign unused_addr = ^mem_a[31:18];

   assign is_io    = (mem_a[17:16] == 2'b11);
   assign io_rd    = is_io & ~mem_wr;
   assign io_wr    = is_io & mem_wr;
   assign hit_data = (mem_a[17:0] == IoDataAddr);
   assign hit_cnt  = (mem_a[17:2] == IoCntAddr[17:2]);
   assign hit_stop = (mem_a[17:0] == IoCntAddr);

   assign ram_a     = mem_a[RAM_AW-1:0];
   assign ram_wdata = mem_dout;
   assign ram_we    = mem_wr & ~is_io;
   // The RX byte is consumed in the same cycle it is sampled into io_byte_q.
   assign rx_pop    = ~rst_in & io_rd & hit_data & rx_valid;

   always_ff @(posedge clk_in) begin
      if (rst_in) cnt_q <= '0;
      else        cnt_q <= cnt_q + 32'd1;
   end

   // Read path: source select and IO byte registered, RAM data arrives one cycle later.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         src_q     <= SrcZero;
         io_byte_q <= 8'h00;
         snap_q    <= '0;
      end else begin
         io_byte_q <= 8'h00;
         if (!is_io) begin
            src_q <= mem_wr ? SrcZero : SrcRam;
         end else if (mem_wr) begin
            src_q <= SrcZero;
         end else if (hit_data) begin
            src_q     <= SrcRx;
            io_byte_q <= rx_valid ? rx_data : 8'h00;
         end else if (hit_cnt) begin
            src_q <= SrcCnt;
            if (mem_a[1:0] == 2'd0) begin
               snap_q    <= cnt_q;
               io_byte_q <= cnt_q[7:0];
            end else begin
               io_byte_q <= snap_byte(snap_q, mem_a[1:0]);
            end
         end else begin
            src_q <= SrcZero;
         end
      end
   end

   always_comb begin
      mem_din = 8'h00;
      case (src_q)
         SrcRam:        mem_din = ram_rdata;
         SrcRx, SrcCnt: mem_din = io_byte_q;
         default:       ;
      endcase
   end

   // Only RUN accepts IO writes; the stop write queues a 0x00 marker.
   always_comb begin
      push      = 1'b0;
      push_data = mem_dout;
      go_drain  = 1'b0;
      if (state_q == StRun && io_wr) begin
         if (hit_data && mem_dout != 8'h00) begin
            push = 1'b1;
         end else if (hit_stop) begin
            push      = 1'b1;
            push_data = 8'h00;
            go_drain  = 1'b1;
         end
      end
   end

   assign tx_valid       = ~fifo_empty;
   assign pop            = tx_valid & tx_ready;
   assign io_buffer_full = (fifo_count >= NearFull);

   always_ff @(posedge clk_in) begin
      if (rst_in) overflow_q <= 1'b0;
      else if (push && fifo_full) overflow_q <= 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q        <= StRun;
         program_finish <= 1'b0;
      end else begin
         case (state_q)
            StRun: if (go_drain) state_q <= StDrain;
            StDrain: begin
               if (fifo_empty) begin
                  state_q        <= StDone;
                  program_finish <= 1'b1;
               end
            end
            StDone:  program_finish <= 1'b1;
            default: state_q <= StRun;
         endcase
      end
   end

   mem_io_responder_tx_fifo #(
      .DEPTH(TX_DEPTH)
   ) tx_fifo (
      .clk      (clk_in),
      .rst      (rst_in),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .head     (tx_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a behavioural RAM and TX capture log.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        program_finish;

   int n_cmp = 0;
   int n_bad = 0;
   int pop_cnt = 0;
   logic [7:0] tx_log [$];
   logic [7:0] ram_model [131072];

   mem_io_responder #(
      .TX_DEPTH(8),
      .RAM_AW  (17)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .mem_a         (mem_a),
      .mem_dout      (mem_dout),
      .mem_wr        (mem_wr),
      .mem_din       (mem_din),
      .io_buffer_full(io_buffer_full),
      .ram_a         (ram_a),
      .ram_we        (ram_we),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_pop        (rx_pop),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .program_finish(program_finish)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (ram_we) ram_model[ram_a] <= ram_wdata;
      ram_rdata <= ram_model[ram_a];
   end

   always @(posedge clk_in) begin
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (rx_pop) pop_cnt++;
   end

   task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a = a; mem_wr = wr; mem_dout = d;
      @(posedge clk_in); #1;
      mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk_in); #1; end
   endtask

   task automatic do_reset();
      rst_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
      rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      idle(2);
      rst_in = 1'b0;
      tx_log.delete();
   endtask

   function automatic logic [7:0] log_at(input int idx);
      if (idx < tx_log.size()) return tx_log[idx];
      return 8'hxx;
   endfunction

   task automatic test_reset();
      rst_in = 1'b1; mem_wr = 1'b0; mem_dout = 8'h00; tx_ready = 1'b0;
      mem_a = 32'h30000; rx_valid = 1'b1; rx_data = 8'h99;
      #1;
      n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
      idle(2);
      n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      n_cmp++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", io_buffer_full); end
      n_cmp++; if (program_finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", program_finish); end
      n_cmp++; if (dut.overflow_q !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", dut.overflow_q); end
      rst_in = 1'b0; rx_valid = 1'b0; mem_a = 32'h0;
   endtask

   task automatic test_ram();
      do_reset();
      cycle(32'h00010, 1'b1, 8'hA5);
      mem_a = 32'h00010; mem_wr = 1'b0; #1;
      n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL ram_early: got %h want 00", mem_din); end
      @(posedge clk_in); #1; mem_a = 32'h0;
      n_cmp++; if (mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_read: got %h want a5", mem_din); end
      cycle(32'h20020, 1'b1, 8'h5A);
      cycle(32'h20020, 1'b0, 8'h00);
      n_cmp++; if (mem_din !== 8'h5A) begin n_bad++; $display("FAIL ram_high: got %h want 5a", mem_din); end
      mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h00; #1;
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL ram_we_io: got %b want 0", ram_we); end
      mem_a = 32'h00030; #1;
      n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL ram_we_ram: got %b want 1", ram_we); end
      mem_a = 32'h0; mem_wr = 1'b0;
      idle(1);
   endtask

   task automatic test_tx_filter();
      do_reset();
      tx_ready = 1'b1;
      cycle(32'h30000, 1'b1, 8'h48);
      cycle(32'h30000, 1'b1, 8'h00);
      cycle(32'h30000, 1'b1, 8'h69);
      idle(4);
      n_cmp++; if (tx_log.size() !== 2) begin n_bad++; $display("FAIL tx_filter_len: got %0d want 2", tx_log.size()); end
      n_cmp++; if (log_at(0) !== 8'h48) begin n_bad++; $display("FAIL tx_filter_0: got %h want 48", log_at(0)); end
      n_cmp++; if (log_at(1) !== 8'h69) begin n_bad++; $display("FAIL tx_filter_1: got %h want 69", log_at(1)); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         cycle(32'h30000, 1'b1, 8'(i));
         if (i == 5) begin
            n_cmp++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL full_after5: got %b want 0", io_buffer_full); end
         end
         if (i == 6) begin
            n_cmp++; if (io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL full_after6: got %b want 1", io_buffer_full); end
         end
         if (i == 8) begin
            n_cmp++; if (dut.overflow_q !== 1'b0) begin n_bad++; $display("FAIL overflow_early: got %b want 0", dut.overflow_q); end
         end
      end
      n_cmp++; if (dut.overflow_q !== 1'b1) begin n_bad++; $display("FAIL overflow_set: got %b want 1", dut.overflow_q); end
      tx_ready = 1'b1;
      for (int k = 0; k < 40 && tx_log.size() < 8; k++) idle(1);
      idle(2);
      n_cmp++; if (tx_log.size() !== 8) begin n_bad++; $display("FAIL full_len: got %0d want 8", tx_log.size()); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (log_at(i) !== 8'(i + 1)) begin n_bad++; $display("FAIL full_byte%0d: got %h want %h", i, log_at(i), 8'(i + 1)); end
      end
      n_cmp++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL full_cleared: got %b want 0", io_buffer_full); end
      n_cmp++; if (dut.overflow_q !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky: got %b want 1", dut.overflow_q); end
   endtask

   task automatic test_counter();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(32'h30004, 1'b0, 8'h00);
         n_cmp++; if (mem_din !== 8'(i)) begin n_bad++; $display("FAIL counter_%0d: got %h want %h", i, mem_din, 8'(i)); end
      end
      mem_a = 32'h30004; mem_wr = 1'b0;
      force dut.cnt_q = 32'h12345678;
      @(posedge clk_in); #1;
      release dut.cnt_q;
      mem_a = 32'h0;
      n_cmp++; if (mem_din !== 8'h78) begin n_bad++; $display("FAIL snap_b0: got %h want 78", mem_din); end
      idle(2);
      cycle(32'h30005, 1'b0, 8'h00);
      n_cmp++; if (mem_din !== 8'h56) begin n_bad++; $display("FAIL snap_b1: got %h want 56", mem_din); end
      cycle(32'h30006, 1'b0, 8'h00);
      n_cmp++; if (mem_din !== 8'h34) begin n_bad++; $display("FAIL snap_b2: got %h want 34", mem_din); end
      cycle(32'h30007, 1'b0, 8'h00);
      n_cmp++; if (mem_din !== 8'h12) begin n_bad++; $display("FAIL snap_b3: got %h want 12", mem_din); end
   endtask

   task automatic test_rx();
      do_reset();
      pop_cnt = 0;
      rx_valid = 1'b1; rx_data = 8'h37;
      mem_a = 32'h30000; mem_wr = 1'b0; #1;
      n_cmp++; if (rx_pop !== 1'b1) begin n_bad++; $display("FAIL rx_pop_high: got %b want 1", rx_pop); end
      @(posedge clk_in); #1;
      mem_a = 32'h0; rx_valid = 1'b0; #1;
      n_cmp++; if (mem_din !== 8'h37) begin n_bad++; $display("FAIL rx_data: got %h want 37", mem_din); end
      n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL rx_pop_low: got %b want 0", rx_pop); end
      rx_data = 8'h5E;
      mem_a = 32'h30000; #1;
      n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL rx_pop_empty: got %b want 0", rx_pop); end
      @(posedge clk_in); #1; mem_a = 32'h0;
      n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL rx_empty: got %h want 00", mem_din); end
      n_cmp++; if (pop_cnt !== 1) begin n_bad++; $display("FAIL rx_pop_count: got %0d want 1", pop_cnt); end
   endtask

   task automatic test_unmapped();
      do_reset();
      cycle(32'h30008, 1'b0, 8'h00);
      n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL unmapped_rd: got %h want 00", mem_din); end
      cycle(32'h30008, 1'b1, 8'h44);
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL unmapped_wr: got %b want 0", tx_valid); end
   endtask

   task automatic test_drain();
      do_reset();
      cycle(32'h30000, 1'b1, 8'h11);
      cycle(32'h30000, 1'b1, 8'h22);
      cycle(32'h30004, 1'b1, 8'h55);
      n_cmp++; if (program_finish !== 1'b0) begin n_bad++; $display("FAIL drain_early: got %b want 0", program_finish); end
      tx_ready = 1'b1;
      idle(3);
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
      n_cmp++; if (program_finish !== 1'b0) begin n_bad++; $display("FAIL drain_not_yet: got %b want 0", program_finish); end
      idle(1);
      n_cmp++; if (program_finish !== 1'b1) begin n_bad++; $display("FAIL drain_finish: got %b want 1", program_finish); end
      n_cmp++; if (tx_log.size() !== 3) begin n_bad++; $display("FAIL drain_len: got %0d want 3", tx_log.size()); end
      n_cmp++; if (log_at(0) !== 8'h11) begin n_bad++; $display("FAIL drain_b0: got %h want 11", log_at(0)); end
      n_cmp++; if (log_at(1) !== 8'h22) begin n_bad++; $display("FAIL drain_b1: got %h want 22", log_at(1)); end
      n_cmp++; if (log_at(2) !== 8'h00) begin n_bad++; $display("FAIL drain_b2: got %h want 00", log_at(2)); end
      cycle(32'h30000, 1'b1, 8'h77);
      idle(2);
      n_cmp++; if (tx_log.size() !== 3) begin n_bad++; $display("FAIL done_ignore: got %0d want 3", tx_log.size()); end
      cycle(32'h00040, 1'b1, 8'h3C);
      cycle(32'h00040, 1'b0, 8'h00);
      n_cmp++; if (mem_din !== 8'h3C) begin n_bad++; $display("FAIL done_ram: got %h want 3c", mem_din); end
      n_cmp++; if (program_finish !== 1'b1) begin n_bad++; $display("FAIL done_hold: got %b want 1", program_finish); end
   endtask

   task automatic test_reset_flush();
      do_reset();
      cycle(32'h30000, 1'b1, 8'hAA);
      cycle(32'h30000, 1'b1, 8'hBB);
      cycle(32'h30004, 1'b1, 8'h00);
      mem_a = 32'h30004; rx_valid = 1'b0;
      do_reset();
      tx_ready = 1'b1;
      idle(4);
      n_cmp++; if (tx_log.size() !== 0) begin n_bad++; $display("FAIL flush_len: got %0d want 0", tx_log.size()); end
      n_cmp++; if (program_finish !== 1'b0) begin n_bad++; $display("FAIL flush_finish: got %b want 0", program_finish); end
      cycle(32'h30000, 1'b1, 8'h41);
      idle(2);
      n_cmp++; if (log_at(0) !== 8'h41 || tx_log.size() !== 1) begin
         n_bad++; $display("FAIL flush_run: got %h (len %0d) want 41 (len 1)", log_at(0), tx_log.size());
      end
   endtask

   initial begin
      rst_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
      rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      test_reset();
      test_ram();
      test_tx_filter();
      test_full();
      test_counter();
      test_rx();
      test_unmapped();
      test_drain();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, meaning UART transmit FIFO depth in bytes (power of two, >=4).
REQ-002 SHALL have parameter RAM_AW, default 17, meaning RAM byte-address width.
REQ-003 SHALL have port clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port mem_a  input  32  CPU byte address.
REQ-006 SHALL have port mem_dout  input  8  CPU write data.
REQ-007 SHALL have port mem_wr  input  1  CPU write strobe (1 = write, 0 = read).
REQ-008 SHALL have port mem_din  output  8  read data returned to CPU.
REQ-009 SHALL have port io_buffer_full  output  1  UART path near-full back-pressure to CPU.
REQ-010 SHALL have port ram_a  output  RAM_AW  RAM address, equal to mem_a[RAM_AW-1:0].
REQ-011 SHALL have port ram_we  output  1  RAM write enable.
REQ-012 SHALL have port ram_wdata  output  8  RAM write data, equal to mem_dout.
REQ-013 SHALL have port ram_rdata  input  8  RAM read data, valid one cycle after the address.
REQ-014 SHALL have ports rx_data  input  8, rx_valid  input  1, and rx_pop  output  1  for the UART receive byte stream.
REQ-015 SHALL have ports tx_data  output  8, tx_valid  output  1, and tx_ready  input  1  for the UART transmit stream.
REQ-016 SHALL have port program_finish  output  1  program-stop indication.

Function
REQ-017 SHALL decode an access as IO when mem_a[17:16]==2'b11 and as RAM otherwise.
REQ-018 SHALL drive ram_we = mem_wr & RAM-decode combinationally, with zero latency.
REQ-019 SHALL return read data on mem_din exactly one cycle after the read address; a registered source select (RAM/RX/CNT/ZERO) SHALL mux ram_rdata or the registered IO byte.
REQ-020 On an IO read of 0x30000 with rx_valid=1, SHALL pulse rx_pop for one cycle and return rx_data next cycle; with rx_valid=0, SHALL return 0x00 and not pop.
REQ-021 SHALL run a 32-bit cycle counter that increments every cycle from 0 after reset and wraps at 2^32.
REQ-022 On an IO read of 0x30004, SHALL latch the counter into a snapshot and return snapshot[7:0]; reads of 0x30005..0x30007 SHALL return snapshot bytes 1..3 without relatching.
REQ-023 On an IO write of 0x30000 with nonzero data, SHALL push the byte into the TX FIFO; zero data SHALL be ignored.
REQ-024 A push to a full FIFO SHALL drop the byte and set a sticky overflow flag, cleared only by reset.
REQ-025 SHALL drive tx_valid = FIFO not empty and tx_data = FIFO head; on tx_valid & tx_ready the head SHALL pop.
REQ-026 A simultaneous push and pop SHALL leave the FIFO count unchanged; FIFO pointers SHALL wrap modulo TX_DEPTH.
REQ-027 SHALL assert io_buffer_full when FIFO count >= TX_DEPTH-2, leaving margin for in-flight writes.
REQ-028 SHALL implement states RUN, DRAIN, and DONE.
REQ-029 In RUN, an IO write to 0x30004 SHALL push 0x00 (bypassing the zero filter) and transition to DRAIN.
REQ-030 DRAIN SHALL transition to DONE when the FIFO is empty and no pop is in progress.
REQ-031 In DONE, SHALL hold program_finish=1 and ignore all further IO writes; RAM accesses SHALL still be served.
REQ-032 Unmapped IO addresses SHALL return 0x00 on reads and be ignored on writes.
REQ-033 A same-cycle IO read and rx_valid deassertion SHALL use the values sampled in that cycle.

Reset
REQ-034 On rst_in=1 at a clock edge, SHALL set mem_din=0x00, rx_pop=0, tx_valid=0, io_buffer_full=0, program_finish=0, counter=0, snapshot=0, FIFO empty, overflow=0, state=RUN.
REQ-035 Reset asserted mid-drain or mid-read SHALL discard pending FIFO contents and any pending read without emitting them.

Structure
REQ-036 IO addresses (0x30000, 0x30004), the state encodings, and the read-source encodings SHALL reside in shared const.v.
REQ-037 The transmit buffer SHALL be a sub-module tx_fifo, parameterized by depth, with push/pop/full/empty/count ports.

Verification
REQ-038 The bench SHALL verify: write 0xA5 to RAM 0x00010, then read 0x00010 -> mem_din=0xA5 exactly one cycle after the read.
REQ-039 The bench SHALL verify: IO writes 'H', 0x00, 'i' with tx_ready=1 -> tx emits 0x48 then 0x69 only.
REQ-040 The bench SHALL verify: with tx_ready=0, write 6 bytes (TX_DEPTH=8) -> io_buffer_full=1 after the 6th; a 9th write sets overflow and the FIFO holds 8 bytes.
REQ-041 The bench SHALL verify: read 0x30004 at counter 0x12345678, then 0x30005..0x30007 three cycles later -> returns 0x78, 0x56, 0x34, 0x12.
REQ-042 The bench SHALL verify: write 0x30004 with 2 bytes queued -> tx emits 2 bytes then 0x00; program_finish rises the cycle after the FIFO empties; a later write to 0x30000 is ignored.
REQ-043 The bench SHALL verify: rx_valid=1, rx_data=0x37, read 0x30000 -> rx_pop pulses once and mem_din=0x37 next cycle; with rx_valid=0 -> 0x00.
